// File: rtl/id_stage.sv
// id_stage: RV32I instruction decode stage.
//
// Takes one instruction per handshake from the fetch stage's output slot,
// reads its source registers from the register file in the same cycle,
// decodes it into ALU / memory / branch / jump / writeback controls and
// holds the result in a registered slot for the execute stage.
//
// Ports:
//   clk, rstn_i            clock, synchronous active-low reset
//   flush_i                drop the held slot and refuse the incoming instruction
//   halt_i                 freeze the stage (no accept, slot held even if ack_i)
//   stall_i                operands not ready (no accept)
//   valid_i/instr_i/pc_i   fetch slot
//   ack_o                  fetch slot consumed this cycle (combinational)
//   rs1_addr_o/rs2_addr_o  register file read addresses (from instr_i)
//   rs1_data_i/rs2_data_i  register file read data (same cycle)
//   ack_i                  execute consumed the decoded slot
//   valid_o ... illegal_o  registered decoded slot
module id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn_i,
  input  logic            flush_i,
  input  logic            halt_i,
  input  logic            stall_i,
  input  logic            valid_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            ack_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            ack_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] op_a_o,
  output logic [XLEN-1:0] op_b_o,
  output logic [XLEN-1:0] rs2_val_o,
  output logic [XLEN-1:0] imm_o,
  output logic [3:0]      alu_op_o,
  output logic [1:0]      mem_op_o,
  output logic [2:0]      mem_size_o,
  output logic            branch_o,
  output logic [2:0]      branch_f3_o,
  output logic [1:0]      jump_o,
  output logic [4:0]      rd_o,
  output logic            wb_en_o,
  output logic            illegal_o
);

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic [1:0]      mem_op;
    logic [2:0]      mem_size;
    logic            branch;
    logic [2:0]      branch_f3;
    logic [1:0]      jump;
    logic [4:0]      rd;
    logic            wb_en;
    logic            illegal;
  } slot_t;

  // funct3 -> ALU operation; alt selects SUB/SRA on the shared encodings.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      3'd7:    op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic            valid_q, valid_d;
  slot_t           slot_q, slot_d;
  slot_t           dec_s;
  logic            accept_s;

  logic [6:0]      opcode_s;
  logic [2:0]      f3_s;
  logic [6:0]      f7_s;
  logic [XLEN-1:0] rs1_val_s, rs2_val_s;
  logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, shamt_s;

  assign opcode_s   = instr_i[6:0];
  assign f3_s       = instr_i[14:12];
  assign f7_s       = instr_i[31:25];
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  // x0 always reads as zero, whatever the register file returns.
  assign rs1_val_s = (rs1_addr_o == 5'd0) ? {XLEN{1'b0}} : rs1_data_i;
  assign rs2_val_s = (rs2_addr_o == 5'd0) ? {XLEN{1'b0}} : rs2_data_i;

  assign imm_i_s = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_s = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
  assign imm_u_s = {instr_i[31:12], 12'h000};
  assign imm_j_s = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};
  assign shamt_s = {27'd0, instr_i[24:20]};

  // Halt and flush are already excluded here, so accept implies the slot moves.
  assign accept_s = valid_i && (!valid_q || ack_i) && !flush_i && !halt_i && !stall_i;
  assign ack_o    = accept_s;

  // Decode the incoming instruction into a candidate slot.
  always_comb begin
    dec_s         = '0;
    dec_s.pc      = pc_i;
    dec_s.rd      = instr_i[11:7];
    dec_s.rs2_val = rs2_val_s;
    case (opcode_s)
      OPC_OP: begin
        dec_s.op_a  = rs1_val_s;
        dec_s.op_b  = rs2_val_s;
        dec_s.wb_en = 1'b1;
        if (f7_s == 7'h00) begin
          dec_s.alu_op = alu_from_f3(f3_s, 1'b0);
        end else if ((f7_s == 7'h20) && ((f3_s == 3'd0) || (f3_s == 3'd5))) begin
          dec_s.alu_op = alu_from_f3(f3_s, 1'b1);
        end else begin
          dec_s.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_s.op_a  = rs1_val_s;
        dec_s.op_b  = imm_i_s;
        dec_s.imm   = imm_i_s;
        dec_s.wb_en = 1'b1;
        if (f3_s == 3'd1) begin
          dec_s.op_b    = shamt_s;
          dec_s.alu_op  = ALU_SLL;
          dec_s.illegal = (f7_s != 7'h00);
        end else if (f3_s == 3'd5) begin
          dec_s.op_b    = shamt_s;
          dec_s.alu_op  = f7_s[5] ? ALU_SRA : ALU_SRL;
          dec_s.illegal = (f7_s != 7'h00) && (f7_s != 7'h20);
        end else begin
          dec_s.alu_op = alu_from_f3(f3_s, 1'b0);
        end
      end
      OPC_LOAD: begin
        dec_s.op_a     = rs1_val_s;
        dec_s.op_b     = imm_i_s;
        dec_s.imm      = imm_i_s;
        dec_s.mem_op   = 2'd1;
        dec_s.mem_size = f3_s;
        dec_s.wb_en    = 1'b1;
        dec_s.illegal  = (f3_s == 3'd3) || (f3_s == 3'd6) || (f3_s == 3'd7);
      end
      OPC_STORE: begin
        dec_s.op_a     = rs1_val_s;
        dec_s.op_b     = imm_s_s;
        dec_s.imm      = imm_s_s;
        dec_s.mem_op   = 2'd2;
        dec_s.mem_size = f3_s;
        dec_s.illegal  = (f3_s > 3'd2);
      end
      OPC_BRANCH: begin
        dec_s.op_a      = rs1_val_s;
        dec_s.op_b      = rs2_val_s;
        dec_s.alu_op    = ALU_SUB;
        dec_s.imm       = imm_b_s;
        dec_s.branch    = 1'b1;
        dec_s.branch_f3 = f3_s;
        dec_s.illegal   = (f3_s == 3'd2) || (f3_s == 3'd3);
      end
      OPC_LUI: begin
        dec_s.op_b  = imm_u_s;
        dec_s.imm   = imm_u_s;
        dec_s.wb_en = 1'b1;
      end
      OPC_AUIPC: begin
        dec_s.op_a  = pc_i;
        dec_s.op_b  = imm_u_s;
        dec_s.imm   = imm_u_s;
        dec_s.wb_en = 1'b1;
      end
      OPC_JAL: begin
        dec_s.op_a  = pc_i;
        dec_s.op_b  = 32'd4;
        dec_s.imm   = imm_j_s;
        dec_s.jump  = 2'd1;
        dec_s.wb_en = 1'b1;
      end
      OPC_JALR: begin
        // Link address is pc+4; the jump base travels on rs2_val.
        dec_s.op_a    = pc_i;
        dec_s.op_b    = 32'd4;
        dec_s.imm     = imm_i_s;
        dec_s.jump    = 2'd2;
        dec_s.rs2_val = rs1_val_s;
        dec_s.wb_en   = 1'b1;
      end
      default: begin
        // Also catches instr[1:0] != 2'b11, since opcodes are matched in full.
        dec_s.illegal = 1'b1;
      end
    endcase
    // An illegal instruction must have no side effects downstream.
    if (dec_s.illegal) begin
      dec_s.wb_en  = 1'b0;
      dec_s.mem_op = 2'd0;
      dec_s.branch = 1'b0;
      dec_s.jump   = 2'd0;
    end else begin
      dec_s.wb_en = dec_s.wb_en && (dec_s.rd != 5'd0);
    end
  end

  // Slot next state: flush wins, halt freezes, then accept, then consume.
  always_comb begin
    valid_d = valid_q;
    slot_d  = slot_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (halt_i) begin
      valid_d = valid_q;
    end else if (accept_s) begin
      valid_d = 1'b1;
      slot_d  = dec_s;
    end else if (ack_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
    end
  end

  assign valid_o     = valid_q;
  assign pc_o        = slot_q.pc;
  assign op_a_o      = slot_q.op_a;
  assign op_b_o      = slot_q.op_b;
  assign rs2_val_o   = slot_q.rs2_val;
  assign imm_o       = slot_q.imm;
  assign alu_op_o    = slot_q.alu_op;
  assign mem_op_o    = slot_q.mem_op;
  assign mem_size_o  = slot_q.mem_size;
  assign branch_o    = slot_q.branch;
  assign branch_f3_o = slot_q.branch_f3;
  assign jump_o      = slot_q.jump;
  assign rd_o        = slot_q.rd;
  assign wb_en_o     = slot_q.wb_en;
  assign illegal_o   = slot_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage with hand-computed expected values.
module tb_id_stage;

  logic        clk;
  logic        rstn_i, flush_i, halt_i, stall_i, valid_i, ack_i;
  logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
  logic        ack_o, valid_o, branch_o, wb_en_o, illegal_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_o;
  logic [31:0] pc_o, op_a_o, op_b_o, rs2_val_o, imm_o;
  logic [3:0]  alu_op_o;
  logic [1:0]  mem_op_o, jump_o;
  logic [2:0]  mem_size_o, branch_f3_o;

  int n_vec = 0;
  int n_err = 0;

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .rstn_i(rstn_i), .flush_i(flush_i), .halt_i(halt_i),
    .stall_i(stall_i), .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i),
    .ack_o(ack_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .ack_i(ack_i),
    .valid_o(valid_o), .pc_o(pc_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .rs2_val_o(rs2_val_o), .imm_o(imm_o), .alu_op_o(alu_op_o),
    .mem_op_o(mem_op_o), .mem_size_o(mem_size_o), .branch_o(branch_o),
    .branch_f3_o(branch_f3_o), .jump_o(jump_o), .rd_o(rd_o),
    .wb_en_o(wb_en_o), .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive the fetch slot and register file data, then let it settle.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    valid_i    = v;
    instr_i    = ins;
    pc_i       = pc;
    rs1_data_i = r1;
    rs2_data_i = r2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn_i = 1'b0; flush_i = 1'b0; halt_i = 1'b0; stall_i = 1'b0; ack_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_op_a", op_a_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_ack", 32'(ack_o), 32'd0);
    rstn_i = 1'b1;

    // addi x1,x2,5
    drive(1'b1, 32'h00510093, 32'h100, 32'd7, 32'd0);
    chk("addi_rs1_addr", 32'(rs1_addr_o), 32'd2);
    chk("addi_ack", 32'(ack_o), 32'd1);
    tick();
    chk("addi_valid", 32'(valid_o), 32'd1);
    chk("addi_op_a", op_a_o, 32'd7);
    chk("addi_op_b", op_b_o, 32'd5);
    chk("addi_alu", 32'(alu_op_o), 32'd0);
    chk("addi_rd", 32'(rd_o), 32'd1);
    chk("addi_wb", 32'(wb_en_o), 32'd1);
    chk("addi_pc", pc_o, 32'h100);

    // Backpressure: slot full, ack_i low, lw x3,-4(x1) offered
    drive(1'b1, 32'hFFC0A183, 32'h104, 32'h2000, 32'd0);
    chk("bp_ack", 32'(ack_o), 32'd0);
    tick();
    chk("bp_valid", 32'(valid_o), 32'd1);
    chk("bp_pc_held", pc_o, 32'h100);
    chk("bp_op_a_held", op_a_o, 32'd7);

    // Raise ack_i: lw accepted with no bubble
    ack_i = 1'b1;
    #1;
    chk("lw_ack", 32'(ack_o), 32'd1);
    tick();
    chk("lw_valid", 32'(valid_o), 32'd1);
    chk("lw_pc", pc_o, 32'h104);
    chk("lw_op_a", op_a_o, 32'h2000);
    chk("lw_op_b", op_b_o, 32'hFFFFFFFC);
    chk("lw_mem_op", 32'(mem_op_o), 32'd1);
    chk("lw_mem_size", 32'(mem_size_o), 32'd2);
    chk("lw_rd", 32'(rd_o), 32'd3);
    chk("lw_wb", 32'(wb_en_o), 32'd1);

    // Flush with valid_o, ack_i and valid_i all high
    flush_i = 1'b1;
    drive(1'b1, 32'h00510093, 32'h108, 32'd1, 32'd0);
    chk("flush_ack", 32'(ack_o), 32'd0);
    tick();
    chk("flush_valid", 32'(valid_o), 32'd0);
    flush_i = 1'b0;

    // sub x5,x6,x7 into the empty slot
    ack_i = 1'b0;
    drive(1'b1, 32'h407302B3, 32'h200, 32'd10, 32'd3);
    chk("sub_rs1_addr", 32'(rs1_addr_o), 32'd6);
    chk("sub_rs2_addr", 32'(rs2_addr_o), 32'd7);
    chk("sub_ack", 32'(ack_o), 32'd1);
    tick();
    chk("sub_alu", 32'(alu_op_o), 32'd1);
    chk("sub_op_a", op_a_o, 32'd10);
    chk("sub_op_b", op_b_o, 32'd3);
    chk("sub_rs2_val", rs2_val_o, 32'd3);
    chk("sub_rd", 32'(rd_o), 32'd5);

    // Stall with a valid fetch slot: no accept, slot held
    stall_i = 1'b1;
    drive(1'b1, 32'h00100013, 32'h204, 32'd0, 32'd0);
    chk("stall_ack", 32'(ack_o), 32'd0);
    tick();
    chk("stall_valid", 32'(valid_o), 32'd1);
    chk("stall_pc", pc_o, 32'h200);
    stall_i = 1'b0;

    // Halt with ack_i high: slot frozen
    halt_i = 1'b1;
    ack_i  = 1'b1;
    #1;
    chk("halt_ack", 32'(ack_o), 32'd0);
    tick();
    chk("halt_valid", 32'(valid_o), 32'd1);
    chk("halt_pc", pc_o, 32'h200);
    chk("halt_alu", 32'(alu_op_o), 32'd1);
    halt_i = 1'b0;

    // All-ones instruction is illegal
    drive(1'b1, 32'hFFFFFFFF, 32'h300, 32'd1, 32'd1);
    chk("ill_ack", 32'(ack_o), 32'd1);
    tick();
    chk("ill_valid", 32'(valid_o), 32'd1);
    chk("ill_flag", 32'(illegal_o), 32'd1);
    chk("ill_wb", 32'(wb_en_o), 32'd0);
    chk("ill_mem", 32'(mem_op_o), 32'd0);
    chk("ill_jump", 32'(jump_o), 32'd0);

    // addi x0,x0,1 with garbage on the read port
    drive(1'b1, 32'h00100013, 32'h304, 32'hDEAD, 32'hBEEF);
    tick();
    chk("x0_wb", 32'(wb_en_o), 32'd0);
    chk("x0_op_a", op_a_o, 32'd0);
    chk("x0_op_b", op_b_o, 32'd1);
    chk("x0_illegal", 32'(illegal_o), 32'd0);

    // beq x1,x2,+8
    drive(1'b1, 32'h00208463, 32'h308, 32'd5, 32'd6);
    tick();
    chk("beq_branch", 32'(branch_o), 32'd1);
    chk("beq_imm", imm_o, 32'd8);
    chk("beq_alu", 32'(alu_op_o), 32'd1);
    chk("beq_wb", 32'(wb_en_o), 32'd0);
    chk("beq_op_b", op_b_o, 32'd6);
    chk("beq_f3", 32'(branch_f3_o), 32'd0);

    // jal x1,+16
    drive(1'b1, 32'h010000EF, 32'h30C, 32'd0, 32'd0);
    tick();
    chk("jal_jump", 32'(jump_o), 32'd1);
    chk("jal_op_a", op_a_o, 32'h30C);
    chk("jal_op_b", op_b_o, 32'd4);
    chk("jal_imm", imm_o, 32'd16);
    chk("jal_wb", 32'(wb_en_o), 32'd1);

    // jalr x0,0(x5)
    drive(1'b1, 32'h00028067, 32'h310, 32'h4000, 32'd9);
    tick();
    chk("jalr_jump", 32'(jump_o), 32'd2);
    chk("jalr_base", rs2_val_o, 32'h4000);
    chk("jalr_op_a", op_a_o, 32'h310);
    chk("jalr_wb", 32'(wb_en_o), 32'd0);

    // srai x4,x4,3
    drive(1'b1, 32'h40325213, 32'h314, 32'h80000000, 32'd0);
    tick();
    chk("srai_alu", 32'(alu_op_o), 32'd7);
    chk("srai_op_b", op_b_o, 32'd3);
    chk("srai_op_a", op_a_o, 32'h80000000);
    chk("srai_illegal", 32'(illegal_o), 32'd0);

    // OP with funct7 = 0x01 is not RV32I
    drive(1'b1, 32'h02000033, 32'h318, 32'd0, 32'd0);
    tick();
    chk("op_f7_illegal", 32'(illegal_o), 32'd1);

    // sw x2,8(x1)
    drive(1'b1, 32'h0020A423, 32'h31C, 32'h1000, 32'h55AA);
    tick();
    chk("sw_mem_op", 32'(mem_op_o), 32'd2);
    chk("sw_op_b", op_b_o, 32'd8);
    chk("sw_data", rs2_val_o, 32'h55AA);
    chk("sw_wb", 32'(wb_en_o), 32'd0);
    chk("sw_illegal", 32'(illegal_o), 32'd0);

    // Consume with no new instruction: slot empties
    drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0);
    tick();
    chk("drain_valid", 32'(valid_o), 32'd0);

    // Reset mid-operation drops a full slot
    ack_i = 1'b0;
    drive(1'b1, 32'h00510093, 32'h400, 32'd7, 32'd0);
    tick();
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    rstn_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0);
    tick();
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_pc", pc_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
